// File: rtl/rtc_time_core_if.sv
// rtc_time_core_if: key-pulse inputs and display/strobe outputs of the time core.
// With RTC_ALARM_EN defined the bundle also carries Alarm_hm and Alarm_hit.
interface rtc_time_core_if;
    logic        Set_en, Field_next, Inc, Dec, Mode12;
    logic [23:0] Time_bcd;
    logic        Pm, Blink, Sec_pulse, Day_pulse;
    logic [1:0]  Field_sel;
`ifdef RTC_ALARM_EN
    logic [15:0] Alarm_hm;
    logic        Alarm_hit;
    modport master(output Set_en, Field_next, Inc, Dec, Mode12, Alarm_hm,
                   input Time_bcd, Pm, Field_sel, Blink, Sec_pulse, Day_pulse, Alarm_hit);
    modport slave(input Set_en, Field_next, Inc, Dec, Mode12, Alarm_hm,
                  output Time_bcd, Pm, Field_sel, Blink, Sec_pulse, Day_pulse, Alarm_hit);
`else
    modport master(output Set_en, Field_next, Inc, Dec, Mode12,
                   input Time_bcd, Pm, Field_sel, Blink, Sec_pulse, Day_pulse);
    modport slave(input Set_en, Field_next, Inc, Dec, Mode12,
                  output Time_bcd, Pm, Field_sel, Blink, Sec_pulse, Day_pulse);
`endif
endinterface

// File: rtl/rtc_time_core.sv
// rtc_time_core: 24h time-of-day counter with field-edit set mode and 12h display mapping.
// Optional RTC_ALARM_EN adds an hh:mm:00 alarm compare on counted seconds.
module rtc_time_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int PRESCALE_W = 30
) (
    input  logic           Clk,
    input  logic           Reset_n,
    rtc_time_core_if.slave bus
);
    localparam logic [PRESCALE_W-1:0] LAST      = PRESCALE_W'(CLK_FREQ - 1);
    localparam logic [PRESCALE_W-1:0] HALF_LAST = PRESCALE_W'(CLK_FREQ / 2 - 1);

    typedef enum logic [1:0] {SEC = 2'd0, MIN = 2'd1, HOUR = 2'd2} field_t;

    field_t                field, field_nx;
    logic [PRESCALE_W-1:0] presc, half_cnt;
    logic [5:0]            sec, min, sec_n, min_n;
    logic [4:0]            hour, hour_n, hour_disp;
    logic                  set_q, tick, edit, up, sec_wrap, min_wrap;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Field-local wrap; carries between fields are handled by the callers.
    function automatic logic [5:0] wrap(input logic [5:0] v, input logic [5:0] top, input logic inc);
        return inc ? (v == top ? 6'd0 : v + 6'd1) : (v == 6'd0 ? top : v - 6'd1);
    endfunction

    assign tick          = !bus.Set_en && presc == LAST;
    assign edit          = bus.Set_en && (bus.Inc ^ bus.Dec);
    assign up            = tick || bus.Inc;
    assign sec_wrap      = sec == 6'd59;
    assign min_wrap      = min == 6'd59;
    assign bus.Field_sel = field;

    always_comb begin
        sec_n     = (tick || (edit && field == SEC)) ? wrap(sec, 6'd59, up) : sec;
        min_n     = ((tick && sec_wrap) || (edit && field == MIN)) ? wrap(min, 6'd59, up) : min;
        hour_n    = ((tick && sec_wrap && min_wrap) || (edit && field == HOUR)) ?
                    5'(wrap({1'b0, hour}, 6'd23, up)) : hour;
        hour_disp = !bus.Mode12 ? hour : hour == 5'd0 ? 5'd12 : hour > 5'd12 ? hour - 5'd12 : hour;
        field_nx  = !bus.Set_en ? SEC : !bus.Field_next ? field :
                    field == HOUR ? SEC : field_t'(field + 2'd1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) field <= SEC;
        else          field <= field_nx;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            presc         <= '0;
            half_cnt      <= '0;
            sec           <= '0;
            min           <= '0;
            hour          <= '0;
            set_q         <= 1'b0;
            bus.Time_bcd  <= '0;
            bus.Pm        <= 1'b0;
            bus.Blink     <= 1'b0;
            bus.Sec_pulse <= 1'b0;
            bus.Day_pulse <= 1'b0;
`ifdef RTC_ALARM_EN
            bus.Alarm_hit <= 1'b0;
`endif
        end else begin
            presc         <= (bus.Set_en || tick) ? '0 : presc + 1'b1;
            set_q         <= bus.Set_en;
            // Blink phase restarts high on every set-mode entry.
            half_cnt      <= (!bus.Set_en || !set_q || half_cnt == HALF_LAST) ? '0 : half_cnt + 1'b1;
            bus.Blink     <= !bus.Set_en ? 1'b0 : !set_q ? 1'b1 :
                             half_cnt == HALF_LAST ? !bus.Blink : bus.Blink;
            sec           <= sec_n;
            min           <= min_n;
            hour          <= hour_n;
            bus.Time_bcd  <= {to_bcd({1'b0, hour_disp}), to_bcd(min), to_bcd(sec)};
            bus.Pm        <= bus.Mode12 && hour >= 5'd12;
            bus.Sec_pulse <= tick;
            bus.Day_pulse <= tick && sec_wrap && min_wrap && hour == 5'd23;
`ifdef RTC_ALARM_EN
            bus.Alarm_hit <= tick && sec_n == 6'd0 &&
                             {to_bcd({1'b0, hour_n}), to_bcd(min_n)} == bus.Alarm_hm;
`endif
        end
    end
endmodule

// File: doc/rtc_time_core.md
Name: rtc_time_core

Overview:
Parametrised time-of-day core for the seven-segment clock family. It keeps hours, minutes and seconds as BCD, supports 24h/12h display, and has a field-editing set mode with independent per-field increment and decrement. It emits one-cycle second and day-rollover strobes for downstream calendar and alarm blocks. The core sits between the key debouncers, which supply the pulse inputs, and the hex display driver, which consumes Time_bcd.

Parameters:
CLK_FREQ, 50_000_000, Clk cycles per second; must be ≥ 4 and even.
PRESCALE_W, 30, width of the prescaler counter; must satisfy 2^PRESCALE_W > CLK_FREQ.

Ports:
Clk  in  1  system clock
Reset_n  in  1  reset
Set_en  in  1  level; 1 = set mode, counting frozen
Field_next  in  1  one-cycle pulse; advance the edited field
Inc  in  1  one-cycle pulse; increment the selected field
Dec  in  1  one-cycle pulse; decrement the selected field
Mode12  in  1  level; 1 = 12h display, 0 = 24h display
Time_bcd  out  24  {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}, registered
Pm  out  1  1 when Mode12=1 and internal hour ≥ 12; else 0
Field_sel  out  2  0 = SEC, 1 = MIN, 2 = HOUR; 3 is never driven
Blink  out  1  field-blink phase for the display
Sec_pulse  out  1  one-cycle strobe per counted second
Day_pulse  out  1  one-cycle strobe on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset: Reset_n is asynchronous, active-low; clock is Clk. All state and outputs are 0.
  - Internal time 00:00:00, prescaler 0, Field_sel 0.
  - Time_bcd is 24'h000000 with Mode12=0. With Mode12=1 it shows 12:00:00 one cycle after reset release.
- Prescaler:
  - Counts 0..CLK_FREQ-1 while Set_en=0.
  - The tick fires on the cycle the count equals CLK_FREQ-1, and the count wraps to 0.
- Tick (Set_en=0):
  - Seconds ones digit increments. Carries ripple sec -> min -> hour within the same cycle.
  - Limits: ones 9 -> 0 with carry; sec/min tens 5 -> 0 with carry; hour 23 -> 00.
  - Sec_pulse=1 on the cycle after the tick.
  - Day_pulse=1 in the same cycle as Sec_pulse when the time wrapped to 00:00:00.
- Set mode entry (Set_en rises):
  - Prescaler is held at 0 and Field_sel is forced to 0 (SEC).
  - No ticks, Sec_pulse or Day_pulse while Set_en=1.
  - A prescaler at CLK_FREQ-1 on the entry cycle does not tick.
- Field_next: advances Field_sel SEC -> MIN -> HOUR -> SEC.
- Inc/Dec on the selected field:
  - Wraps within that field only, with no carry or borrow into other fields.
  - Ranges: sec 00..59, min 00..59, hour 00..23. Examples: 59+1 = 00, 00-1 = 59, hour 23+1 = 00, 00-1 = 23.
  - Inc and Dec in the same cycle: both ignored.
  - Field_next together with Inc or Dec: the edit applies to the old field, then the field advances.
- In counting mode (Set_en=0): Inc, Dec and Field_next are ignored.
- Set mode exit (Set_en falls): prescaler restarts from 0, so the first tick comes CLK_FREQ cycles after the falling-edge cycle.
- 12h display mapping (display only; internal time stays 24h):
  - hour 0 -> 12, Pm=0
  - hours 1..11 unchanged, Pm=0
  - hour 12 -> 12, Pm=1
  - hours 13..23 -> hour-12, Pm=1
  - Mode12 changes take effect on Time_bcd one cycle later.
- Blink:
  - With Set_en=1, Blink toggles every CLK_FREQ/2 cycles using a separate half-second counter, starting at 1 on entry.
  - With Set_en=0, Blink=0.
- Latency: Time_bcd and Pm are registered and lag internal time by exactly 1 cycle.
- Asserting Reset_n mid-edit returns everything to reset values immediately.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined:
  - Adds input Alarm_hm[15:0], BCD {h_tens,h_ones,m_tens,m_ones} in 24h, and output Alarm_hit.
  - Alarm_hit is a one-cycle pulse coincident with Sec_pulse when the new time equals Alarm_hm:00.
  - Alarm_hit never fires in set mode or from Inc/Dec edits.
  - Alarm_hm values with an hour > 23 or a minute > 59 never match.
- Undefined: the port and its logic are absent; everything else is unchanged.

Test Plan:
1. CLK_FREQ=10; release reset and run 30 cycles -> Sec_pulse at cycles 10/20/30 and Time_bcd 000003.
2. Set time 23:59:58 via set mode, exit, run 20 cycles -> second tick gives Time_bcd 000000 with Day_pulse=1 for exactly one cycle.
3. Set mode, Field_sel=SEC at 59, Inc -> 00 with minutes unchanged; Field_next twice then Dec at hour 00 -> 23.
4. Inc and Dec pulsed in the same cycle -> no change; Inc while Set_en=0 -> no change.
5. Mode12=1 with internal 00:xx, 12:xx and 13:xx -> displayed hours 12/Pm=0, 12/Pm=1 and 01/Pm=1.
6. RTC_ALARM_EN defined, Alarm_hm=16'h0001, time 00:00:59 -> Alarm_hit on the tick to 00:01:00 only; no hit when 00:01 is reached by Inc.
